// File: rtl/fb_write_sched.sv
// Write-port scheduler for the mmio_vga framebuffer window: round-robin between two
// requesters, with a full-window fill engine that takes absolute priority.
module fb_write_sched #(
  parameter logic [15:0] BASE_ADDR = 16'h200,
  parameter logic [15:0] LAST_ADDR = 16'h5FF,
  parameter int          DATA_W    = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic [15:0]       a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ack,
  input  logic              b_req,
  input  logic [15:0]       b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ack,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_value,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              err_oor,
  output logic [15:0]       wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_en
);

  // state | meaning
  // IDLE  | arbitrate A/B round-robin, accept fill_start
  // FILL  | one fill write per clock from BASE_ADDR to LAST_ADDR, requesters stalled
  localparam logic IDLE = 1'b0;
  localparam logic FILL = 1'b1;

  logic              state;
  logic [15:0]       cnt;
  logic [DATA_W-1:0] fill_val;
  logic              last_b;

  logic              arb_ok;
  logic [15:0]       gnt_addr;
  logic [DATA_W-1:0] gnt_data;
  logic              gnt_in_win;

  // Acks are gated by reset so nothing is consumed while the block is held in reset.
  assign arb_ok = reset_n && (state == IDLE) && !fill_start;
  assign a_ack  = arb_ok && a_req && (!b_req || last_b);
  assign b_ack  = arb_ok && b_req && (!a_req || !last_b);

  assign gnt_addr   = a_ack ? a_addr : b_addr;
  assign gnt_data   = a_ack ? a_data : b_data;
  assign gnt_in_win = (gnt_addr >= BASE_ADDR) && (gnt_addr <= LAST_ADDR);

  assign fill_busy = (state == FILL);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= BASE_ADDR;
      fill_val  <= '0;
      last_b    <= 1'b1;
      wr_addr   <= BASE_ADDR;
      wr_data   <= '0;
      wr_en     <= 1'b0;
      fill_done <= 1'b0;
      err_oor   <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      fill_done <= 1'b0;
      err_oor   <= 1'b0;
      if (state == FILL) begin
        wr_en   <= 1'b1;
        wr_addr <= cnt;
        wr_data <= fill_val;
        if (cnt == LAST_ADDR) begin
          fill_done <= 1'b1;
          state     <= IDLE;
        end else begin
          cnt <= cnt + 16'd1;
        end
      end else if (fill_start) begin
        state    <= FILL;
        cnt      <= BASE_ADDR;
        fill_val <= fill_value;
      end else if (a_ack || b_ack) begin
        last_b <= b_ack;
        if (gnt_in_win) begin
          wr_en   <= 1'b1;
          wr_addr <= gnt_addr;
          wr_data <= gnt_data;
        end else begin
          err_oor <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fb_write_sched.sv
// Directed bench for fb_write_sched: reset, single grants, round-robin contention,
// out-of-window drops, full fill with stalled requester, and reset mid-fill.
module tb_fb_write_sched;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        a_req, b_req, fill_start;
  logic [15:0] a_addr, b_addr;
  logic [7:0]  a_data, b_data, fill_value;
  logic        a_ack, b_ack, fill_busy, fill_done, err_oor, wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;

  int checks = 0;
  int errors = 0;

  fb_write_sched dut (
    .clock(clock), .reset_n(reset_n),
    .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack),
    .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack),
    .fill_start(fill_start), .fill_value(fill_value),
    .fill_busy(fill_busy), .fill_done(fill_done), .err_oor(err_oor),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    a_req = 0; b_req = 0; fill_start = 0;
    a_addr = 0; b_addr = 0; a_data = 0; b_data = 0; fill_value = 0;

    // Reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      a_req = 1'($urandom); b_req = 1'($urandom); fill_start = 1'($urandom);
      a_addr = 16'($urandom); b_addr = 16'($urandom);
      a_data = 8'($urandom); b_data = 8'($urandom); fill_value = 8'($urandom);
      #1;
      chk("rst_a_ack", a_ack, 0);
      chk("rst_b_ack", b_ack, 0);
      step();
    end
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 16'h200);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_fill_busy", fill_busy, 0);
    chk("rst_err_oor", err_oor, 0);

    a_req = 0; b_req = 0; fill_start = 0;
    reset_n = 1'b1;
    step(); step();
    chk("idle_wr_en", wr_en, 0);
    chk("idle_wr_addr", wr_addr, 16'h200);

    // Single A request
    a_req = 1; a_addr = 16'h234; a_data = 8'h5A;
    #1;
    chk("singleA_a_ack", a_ack, 1);
    chk("singleA_b_ack", b_ack, 0);
    step();
    a_req = 0;
    #1;
    chk("singleA_wr_en", wr_en, 1);
    chk("singleA_wr_addr", wr_addr, 16'h234);
    chk("singleA_wr_data", wr_data, 8'h5A);
    chk("singleA_ack_gone", a_ack, 0);
    step();
    chk("singleA_wr_en_off", wr_en, 0);
    chk("singleA_addr_hold", wr_addr, 16'h234);

    // Single B request at the top of a row; leaves the pointer on B
    b_req = 1; b_addr = 16'h2FF; b_data = 8'h11;
    #1;
    chk("singleB_b_ack", b_ack, 1);
    step();
    b_req = 0;
    #1;
    chk("singleB_wr_addr", wr_addr, 16'h2FF);
    chk("singleB_wr_data", wr_data, 8'h11);

    // Contention: both held for 6 cycles, A wins first
    a_req = 1; a_addr = 16'h300; a_data = 8'hA1;
    b_req = 1; b_addr = 16'h400; b_data = 8'hB2;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_a_ack", a_ack, (i % 2 == 0) ? 1 : 0);
      chk("rr_b_ack", b_ack, (i % 2 == 0) ? 0 : 1);
      step();
      if (i == 5) begin a_req = 0; b_req = 0; end
      chk("rr_wr_en", wr_en, 1);
      chk("rr_wr_addr", wr_addr, (i % 2 == 0) ? 16'h300 : 16'h400);
      chk("rr_wr_data", wr_data, (i % 2 == 0) ? 8'hA1 : 8'hB2);
    end
    step();
    chk("rr_wr_en_off", wr_en, 0);

    // Out of window: just below and just above the window
    b_req = 1; b_addr = 16'h1FF; b_data = 8'hEE;
    #1;
    chk("oor_lo_b_ack", b_ack, 1);
    step();
    chk("oor_lo_err", err_oor, 1);
    chk("oor_lo_wr_en", wr_en, 0);
    chk("oor_lo_addr_hold", wr_addr, 16'h400);
    b_addr = 16'h600;
    #1;
    chk("oor_hi_b_ack", b_ack, 1);
    step();
    b_req = 0;
    chk("oor_hi_err", err_oor, 1);
    chk("oor_hi_wr_en", wr_en, 0);
    chk("oor_hi_data_hold", wr_data, 8'hB2);
    step();
    chk("oor_err_clear", err_oor, 0);

    // Tie after the dropped B grants: A wins, then B; window edges accepted
    a_req = 1; a_addr = 16'h200; a_data = 8'h77;
    b_req = 1; b_addr = 16'h5FF; b_data = 8'h88;
    #1;
    chk("tie_a_ack", a_ack, 1);
    chk("tie_b_ack", b_ack, 0);
    step();
    a_req = 0;
    #1;
    chk("tie_wr_addr", wr_addr, 16'h200);
    chk("tie_wr_en", wr_en, 1);
    chk("tie_err", err_oor, 0);
    chk("tie_b_next", b_ack, 1);
    step();
    b_req = 0;
    chk("tie_b_wr_addr", wr_addr, 16'h5FF);
    chk("tie_b_wr_data", wr_data, 8'h88);

    // Fill with A pending
    a_req = 1; a_addr = 16'h250; a_data = 8'h99;
    fill_start = 1; fill_value = 8'h3C;
    #1;
    chk("fill_start_no_ack", a_ack, 0);
    step();
    fill_start = 0; fill_value = 8'hFF;
    chk("fill_busy_S", fill_busy, 1);
    chk("fill_wr_en_S", wr_en, 0);
    for (int k = 0; k < 1024; k++) begin
      step();
      if (k == 500) begin fill_start = 1; fill_value = 8'h55; end
      if (k == 501) begin fill_start = 0; end
      chk("fill_wr_en", wr_en, 1);
      chk("fill_wr_addr", wr_addr, 32'h200 + k);
      chk("fill_wr_data", wr_data, 8'h3C);
      chk("fill_done", fill_done, (k == 1023) ? 1 : 0);
      chk("fill_busy", fill_busy, (k == 1023) ? 0 : 1);
      chk("fill_a_ack", a_ack, (k == 1023) ? 1 : 0);
    end
    step();
    a_req = 0;
    chk("post_fill_wr_addr", wr_addr, 16'h250);
    chk("post_fill_wr_data", wr_data, 8'h99);
    chk("post_fill_done_clear", fill_done, 0);
    step();
    chk("post_fill_wr_en_off", wr_en, 0);

    // Reset mid-fill
    fill_start = 1; fill_value = 8'h42;
    step();
    fill_start = 0;
    for (int k = 0; k < 100; k++) step();
    chk("midfill_addr_99", wr_addr, 16'h200 + 16'd99);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_fill_busy", fill_busy, 0);
    chk("midrst_wr_en", wr_en, 0);
    chk("midrst_wr_addr", wr_addr, 16'h200);
    chk("midrst_wr_data", wr_data, 0);
    chk("midrst_fill_done", fill_done, 0);
    step(); step();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("after_rst_wr_en", wr_en, 0);
      chk("after_rst_fill_done", fill_done, 0);
    end
    a_req = 1; a_addr = 16'h345; a_data = 8'h6D;
    #1;
    chk("after_rst_a_ack", a_ack, 1);
    step();
    a_req = 0;
    chk("after_rst_wr_en_on", wr_en, 1);
    chk("after_rst_wr_addr", wr_addr, 16'h345);
    chk("after_rst_wr_data", wr_data, 8'h6D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
